// File: rtl/diagnostics_ctrl.sv
// diagnostics_ctrl: SPI-command diagnostics controller (halt, ranged memory read/write, config/status readback)
// Ports:
//   fpga_clk, fpga_reset       clock, asynchronous active-low reset
//   rx_dv, rx_byte             received command/data byte strobe from the SPI slave
//   tx_dv, tx_byte             reply byte load strobe to the SPI slave
//   spi_cs_n                   SPI chip select; a rising edge aborts any range transfer
//   halt                       holds the CPU while memory is owned by this block
//   address, data_out, cs, we  memory bus master outputs
//   mem_data_in                memory read data, valid RD_LATENCY cycles after address changes
//   configuration              board straps, captured once after reset
module diagnostics_ctrl #(
    parameter int ADDR_WIDTH      = 16,
    parameter int CONFIG_WIDTH    = 2,
    parameter int RD_LATENCY      = 1,
    parameter int WE_PULSE_CYCLES = 1
) (
    input  logic                    fpga_clk,
    input  logic                    fpga_reset,
    input  logic                    rx_dv,
    input  logic [7:0]              rx_byte,
    output logic                    tx_dv,
    output logic [7:0]              tx_byte,
    input  logic                    spi_cs_n,
    output logic                    halt,
    output logic [ADDR_WIDTH-1:0]   address,
    input  logic [7:0]              mem_data_in,
    output logic [7:0]              data_out,
    output logic                    cs,
    output logic                    we,
    input  logic [CONFIG_WIDTH-1:0] configuration
);
    localparam int NA = (ADDR_WIDTH + 7) / 8;
    localparam int HW = 16 * NA;
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [2:0] H_LAST = 3'(2 * NA - 1);
    localparam logic [2:0] H_ONE = 3'd1;
    localparam logic [3:0] RD_LAT = 4'(RD_LATENCY);
    localparam logic [3:0] WE_LEN = 4'(WE_PULSE_CYCLES);
    localparam logic [3:0] L_ONE = 4'd1;
    localparam logic [CW-1:0] C_ONE = CW'(1);
    localparam logic [ADDR_WIDTH-1:0] A_ONE = ADDR_WIDTH'(1);

    typedef enum logic [3:0] {
        ST_STARTUP, ST_RUNNING, ST_HALTED, ST_REPLY, ST_HDR, ST_RD_WAIT,
        ST_RD_SEND, ST_WR_IDLE, ST_WR_PULSE, ST_WR_REC, ST_CK_WAIT
    } state_t;

    state_t                r_state, w_state;
    logic                  r_halt, w_halt, r_cs, w_cs, r_we, w_we, r_tx_dv, w_tx_dv;
    logic                  r_abort, w_abort_f, r_ovr, w_ovr, r_wr, w_wr, r_pend, w_pend, r_csn_d;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr;
    logic [7:0]            r_dout, w_dout, r_tx_byte, w_tx_byte, r_cfg, w_cfg, r_csum, w_csum, r_pbyte, w_pbyte;
    logic [HW-9:0]         r_hdr, w_hdr;
    logic [2:0]            r_hcnt, w_hcnt;
    logic [3:0]            r_lat, w_lat;
    logic [CW-1:0]         r_cnt, w_cnt;
    logic                  w_rx, w_abort;
    logic [7:0]            w_byte;
    logic [HW-1:0]         w_hdr_new;

    // A byte that arrived while the FSM was busy with an internal step is replayed one cycle later.
    assign w_rx      = rx_dv | r_pend;
    assign w_byte    = r_pend ? r_pbyte : rx_byte;
    assign w_hdr_new = {r_hdr, w_byte};
    assign w_abort   = spi_cs_n & ~r_csn_d & (r_state inside {ST_HDR, ST_RD_WAIT, ST_RD_SEND,
                       ST_WR_IDLE, ST_WR_PULSE, ST_WR_REC, ST_CK_WAIT});

    always_comb begin
        w_state   = r_state;
        w_halt    = r_halt;
        w_cs      = r_cs;
        w_we      = r_we;
        w_tx_dv   = 1'b0;
        w_tx_byte = r_tx_byte;
        w_abort_f = r_abort;
        w_ovr     = r_ovr;
        w_wr      = r_wr;
        w_pend    = 1'b0;
        w_pbyte   = r_pbyte;
        w_addr    = r_addr;
        w_dout    = r_dout;
        w_cfg     = r_cfg;
        w_csum    = r_csum;
        w_hdr     = r_hdr;
        w_hcnt    = r_hcnt;
        w_lat     = r_lat;
        w_cnt     = r_cnt;
        if (w_abort) begin
            w_state   = ST_HALTED;
            w_cs      = 1'b0;
            w_we      = 1'b0;
            w_abort_f = 1'b1;
        end else begin
            case (r_state)
                ST_STARTUP: begin
                    w_cfg = '0;
                    w_cfg[CONFIG_WIDTH-1:0] = configuration;
                    w_state = ST_RUNNING;
                    w_pend  = w_rx;
                    w_pbyte = w_byte;
                end
                ST_RUNNING, ST_HALTED: begin
                    if (w_rx) begin
                        case (w_byte)
                            8'hAA: begin
                                w_halt  = 1'b1;
                                w_state = ST_HALTED;
                            end
                            8'h55: begin
                                w_halt  = 1'b0;
                                w_state = ST_RUNNING;
                            end
                            8'h77: begin
                                w_tx_byte = r_cfg;
                                w_tx_dv   = 1'b1;
                                w_state   = ST_REPLY;
                            end
                            8'h33: begin
                                w_tx_byte = {r_halt, 5'b0, r_abort, r_ovr};
                                w_tx_dv   = 1'b1;
                                w_abort_f = 1'b0;
                                w_ovr     = 1'b0;
                                w_state   = ST_REPLY;
                            end
                            8'h66, 8'h99: begin
                                w_state = r_halt ? ST_HDR : r_state;
                                w_wr    = w_byte == 8'h99;
                                w_hcnt  = '0;
                                w_csum  = r_halt ? 8'h00 : r_csum;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_REPLY: w_state = w_rx ? (r_halt ? ST_HALTED : ST_RUNNING) : r_state;
                ST_HDR: begin
                    if (w_rx) begin
                        w_hdr  = w_hdr_new[HW-9:0];
                        w_hcnt = r_hcnt + H_ONE;
                        if (r_hcnt == H_LAST) begin
                            w_addr  = w_hdr_new[NA*8 +: ADDR_WIDTH];
                            // A zero length selects the whole 2^ADDR_WIDTH map via the extra counter bit.
                            w_cnt   = {~|w_hdr_new[ADDR_WIDTH-1:0], w_hdr_new[ADDR_WIDTH-1:0]};
                            w_cs    = 1'b1;
                            w_lat   = '0;
                            w_state = r_wr ? ST_WR_IDLE : ST_RD_WAIT;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    w_pend  = w_rx;
                    w_pbyte = w_byte;
                    w_lat   = r_lat + L_ONE;
                    if (r_lat == RD_LAT) begin
                        w_tx_byte = mem_data_in;
                        w_tx_dv   = 1'b1;
                        w_csum    = r_csum + mem_data_in;
                        w_state   = ST_RD_SEND;
                    end
                end
                ST_RD_SEND: begin
                    if (w_rx) begin
                        w_addr    = r_addr + A_ONE;
                        w_cnt     = r_cnt - C_ONE;
                        w_lat     = '0;
                        w_tx_byte = r_cnt == C_ONE ? r_csum : r_tx_byte;
                        w_tx_dv   = r_cnt == C_ONE;
                        w_state   = r_cnt == C_ONE ? ST_CK_WAIT : ST_RD_WAIT;
                    end
                end
                ST_WR_IDLE: begin
                    if (w_rx) begin
                        w_dout  = w_byte;
                        w_we    = 1'b1;
                        w_lat   = L_ONE;
                        w_state = ST_WR_PULSE;
                    end
                end
                ST_WR_PULSE: begin
                    w_ovr   = r_ovr | rx_dv;
                    w_lat   = r_lat + L_ONE;
                    w_we    = r_lat != WE_LEN;
                    w_state = r_lat == WE_LEN ? ST_WR_REC : r_state;
                end
                ST_WR_REC: begin
                    w_ovr     = r_ovr | rx_dv;
                    w_addr    = r_addr + A_ONE;
                    w_csum    = r_csum + r_dout;
                    w_cnt     = r_cnt - C_ONE;
                    w_tx_byte = r_cnt == C_ONE ? r_csum + r_dout : r_tx_byte;
                    w_tx_dv   = r_cnt == C_ONE;
                    w_state   = r_cnt == C_ONE ? ST_CK_WAIT : ST_WR_IDLE;
                end
                ST_CK_WAIT: begin
                    w_cs    = w_rx ? 1'b0 : r_cs;
                    w_state = w_rx ? ST_HALTED : r_state;
                end
                default: w_state = ST_STARTUP;
            endcase
        end
    end

    always_ff @(posedge fpga_clk or negedge fpga_reset) begin
        if (!fpga_reset) begin
            r_state   <= ST_STARTUP;
            r_halt    <= 1'b0;
            r_cs      <= 1'b0;
            r_we      <= 1'b0;
            r_tx_dv   <= 1'b0;
            r_tx_byte <= '0;
            r_abort   <= 1'b0;
            r_ovr     <= 1'b0;
            r_wr      <= 1'b0;
            r_pend    <= 1'b0;
            r_pbyte   <= '0;
            r_csn_d   <= 1'b1;
            r_addr    <= '0;
            r_dout    <= '0;
            r_cfg     <= '0;
            r_csum    <= '0;
            r_hdr     <= '0;
            r_hcnt    <= '0;
            r_lat     <= '0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state;
            r_halt    <= w_halt;
            r_cs      <= w_cs;
            r_we      <= w_we;
            r_tx_dv   <= w_tx_dv;
            r_tx_byte <= w_tx_byte;
            r_abort   <= w_abort_f;
            r_ovr     <= w_ovr;
            r_wr      <= w_wr;
            r_pend    <= w_pend;
            r_pbyte   <= w_pbyte;
            r_csn_d   <= spi_cs_n;
            r_addr    <= w_addr;
            r_dout    <= w_dout;
            r_cfg     <= w_cfg;
            r_csum    <= w_csum;
            r_hdr     <= w_hdr;
            r_hcnt    <= w_hcnt;
            r_lat     <= w_lat;
            r_cnt     <= w_cnt;
        end
    end

    assign tx_dv    = r_tx_dv;
    assign tx_byte  = r_tx_byte;
    assign halt     = r_halt;
    assign address  = r_addr;
    assign data_out = r_dout;
    assign cs       = r_cs;
    assign we       = r_we;
endmodule
